// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Pipeline MEM stage: waits for data_sram responses, aligns and
//            extends load data, drops stale responses after a flush.
// Revision : 1.0
// ============================================================================
module mem_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_to_mem_valid,
  output logic        mem_allowin,
  input  logic [31:0] ex_pc,
  input  logic        ex_res_from_mem,
  input  logic        ex_req_sent,
  input  logic        ex_rf_we,
  input  logic [4:0]  ex_rf_waddr,
  input  logic [31:0] ex_alu_result,
  input  logic [2:0]  ex_ld_op,
  input  logic        ex_excep_en,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  input  logic        flush,
  input  logic        wb_allowin,
  output logic        mem_to_wb_valid,
  output logic [70:0] mem_to_wb_bus,
  output logic [38:0] mem_to_id_bus,
  output logic        mem_to_ex_bus
);

  localparam logic [1:0] c_cnt_max = 2'd2;

  logic        r_mem_valid;
  logic [31:0] r_pc;
  logic        r_res_from_mem;
  logic        r_req_sent;
  logic        r_rf_we;
  logic [4:0]  r_rf_waddr;
  logic [31:0] r_alu_result;
  logic [2:0]  r_ld_op;
  logic        r_excep_en;
  logic [1:0]  r_discard_cnt;
  logic        r_buf_valid;
  logic [31:0] r_buf_data;

  logic        w_wait;
  logic        w_ok_live;
  logic        w_ready_go;
  logic        w_handoff;
  logic        w_in_outstanding;
  logic        w_new_outstanding;
  logic        w_cnt_dec;
  logic [1:0]  w_cnt_inc;
  logic [2:0]  w_cnt_sum;
  logic [1:0]  w_cnt_next;
  logic [31:0] w_raw;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [31:0] w_final_result;
  logic        w_rf_we_out;
  logic        w_stall_load;

  assign w_wait    = r_mem_valid & r_req_sent & ~r_excep_en;
  // A response only counts when no stale responses are still owed.
  assign w_ok_live = data_sram_data_ok & (r_discard_cnt == 2'd0);
  assign w_ready_go = ~w_wait | w_ok_live | r_buf_valid;
  assign w_handoff  = r_mem_valid & w_ready_go & wb_allowin;

  assign mem_allowin     = ~r_mem_valid | (w_ready_go & wb_allowin);
  assign mem_to_wb_valid = r_mem_valid & w_ready_go & ~flush;

  // Requests whose responses will still arrive after a flush must be discarded.
  assign w_in_outstanding  = w_wait & ~r_buf_valid & ~w_ok_live;
  assign w_new_outstanding = ex_req_sent & ex_to_mem_valid;
  assign w_cnt_inc = flush ? ({1'b0, w_in_outstanding} + {1'b0, w_new_outstanding}) : 2'd0;
  assign w_cnt_dec = data_sram_data_ok & (r_discard_cnt != 2'd0);
  assign w_cnt_sum = {1'b0, r_discard_cnt} - {2'b00, w_cnt_dec} + {1'b0, w_cnt_inc};
  assign w_cnt_next = (w_cnt_sum > {1'b0, c_cnt_max}) ? c_cnt_max : w_cnt_sum[1:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mem_valid <= 1'b0;
    end else if (flush) begin
      r_mem_valid <= 1'b0;
    end else if (mem_allowin) begin
      r_mem_valid <= ex_to_mem_valid;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pc           <= 32'd0;
      r_res_from_mem <= 1'b0;
      r_req_sent     <= 1'b0;
      r_rf_we        <= 1'b0;
      r_rf_waddr     <= 5'd0;
      r_alu_result   <= 32'd0;
      r_ld_op        <= 3'd0;
      r_excep_en     <= 1'b0;
    end else if (ex_to_mem_valid & mem_allowin) begin
      r_pc           <= ex_pc;
      r_res_from_mem <= ex_res_from_mem;
      r_req_sent     <= ex_req_sent;
      r_rf_we        <= ex_rf_we;
      r_rf_waddr     <= ex_rf_waddr;
      r_alu_result   <= ex_alu_result;
      r_ld_op        <= ex_ld_op;
      r_excep_en     <= ex_excep_en;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_discard_cnt <= 2'd0;
    end else begin
      r_discard_cnt <= w_cnt_next;
    end
  end

  // Holds a response that arrived while WB was blocked, until handoff.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_buf_valid <= 1'b0;
      r_buf_data  <= 32'd0;
    end else if (flush | w_handoff) begin
      r_buf_valid <= 1'b0;
    end else if (w_wait & w_ok_live & ~wb_allowin & ~r_buf_valid) begin
      r_buf_valid <= 1'b1;
      r_buf_data  <= data_sram_rdata;
    end
  end

  assign w_raw  = r_buf_valid ? r_buf_data : data_sram_rdata;
  assign w_half = r_alu_result[1] ? w_raw[31:16] : w_raw[15:0];

  always_comb begin
    w_byte = w_raw[7:0];
    case (r_alu_result[1:0])
      2'd0:    w_byte = w_raw[7:0];
      2'd1:    w_byte = w_raw[15:8];
      2'd2:    w_byte = w_raw[23:16];
      default: w_byte = w_raw[31:24];
    endcase
  end

  // ld_op is {byte, half, unsigned}; neither size bit set means a word load.
  always_comb begin
    w_load_data = w_raw;
    if (r_ld_op[2]) begin
      w_load_data = {{24{~r_ld_op[0] & w_byte[7]}}, w_byte};
    end else if (r_ld_op[1]) begin
      w_load_data = {{16{~r_ld_op[0] & w_half[15]}}, w_half};
    end
  end

  assign w_final_result = r_res_from_mem ? w_load_data : r_alu_result;
  assign w_rf_we_out    = r_rf_we & r_mem_valid & ~r_excep_en;
  assign w_stall_load   = r_mem_valid & r_res_from_mem & ~w_ready_go;

  assign mem_to_wb_bus = {r_pc, w_rf_we_out, r_rf_waddr, w_final_result, r_excep_en};
  assign mem_to_id_bus = {w_rf_we_out, r_rf_waddr, w_final_result, w_stall_load};
  assign mem_to_ex_bus = r_excep_en & r_mem_valid;

endmodule
`default_nettype wire

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port ex_to_mem_valid, input, 1, EX holds a completed instruction.
REQ-004 SHALL have port mem_allowin, output, 1, MEM accepts an instruction this cycle.
REQ-005 SHALL have port ex_pc, input, 32, instruction PC.
REQ-006 SHALL have port ex_res_from_mem, input, 1, instruction is a load.
REQ-007 SHALL have port ex_req_sent, input, 1, EX had its data_sram request accepted (addr_ok seen).
REQ-008 SHALL have port ex_rf_we / ex_rf_waddr, input, 1/5, register write enable/address.
REQ-009 SHALL have port ex_alu_result, input, 32, ALU result or load address.
REQ-010 SHALL have port ex_ld_op, input, 3, {b, h, u}: byte, half, unsigned; all-zero means word.
REQ-011 SHALL have port ex_excep_en, input, 1, instruction already carries an exception.
REQ-012 SHALL have port data_sram_data_ok / data_sram_rdata, input, 1/32, read or write response.
REQ-013 SHALL have port flush, input, 1, exception/ertn flush from WB.
REQ-014 SHALL have port wb_allowin, input, 1, WB accepts.
REQ-015 SHALL have port mem_to_wb_valid, output, 1, MEM result valid to WB.
REQ-016 SHALL have port mem_to_wb_bus, output, 71, {mem_pc[31:0], mem_rf_we, mem_rf_waddr[4:0], mem_final_result[31:0], mem_excep_en}.
REQ-017 SHALL have port mem_to_id_bus, output, 39, {mem_rf_we&valid, mem_rf_waddr, mem_final_result, mem_stall_load}: forwarding bus.
REQ-018 SHALL have port mem_to_ex_bus, output, 1, mem_excep_en&valid: suppresses younger EX memory requests.

Function
REQ-019 SHALL capture all ex_* fields into stage registers when ex_to_mem_valid & mem_allowin.
REQ-020 SHALL set mem_valid <= ex_to_mem_valid when mem_allowin; clear mem_valid on flush, flush taking priority.
REQ-021 SHALL compute mem_wait = mem_valid & mem_req_sent & ~mem_excep_en.
REQ-022 SHALL assert mem_ready_go = ~mem_wait | (data_sram_data_ok & discard_cnt==0).
REQ-023 SHALL drive mem_allowin = ~mem_valid | (mem_ready_go & wb_allowin); mem_to_wb_valid = mem_valid & mem_ready_go & ~flush.
REQ-024 SHALL keep a 2-bit discard_cnt: +1 at a flush for each outstanding request (the in-stage waiting one, plus the incoming one if ex_req_sent&ex_to_mem_valid); -1 on each data_ok while nonzero; saturate at 2.
REQ-025 SHALL ignore (not forward, not complete) any data_ok arriving while discard_cnt != 0.
REQ-026 SHALL, for loads, select byte by mem_alu_result[1:0], half by mem_alu_result[1]; sign-extend unless u; word passes rdata unchanged.
REQ-027 SHALL drive mem_final_result = load data when mem_res_from_mem, else mem_alu_result.
REQ-028 SHALL assert mem_stall_load = mem_valid & mem_res_from_mem & ~mem_ready_go, telling ID not to forward yet.
REQ-029 SHALL hold a completed load result in a 32-bit buffer if data_ok arrives while wb_allowin is low, and use the buffer until handoff.
REQ-030 SHALL mask mem_rf_we in both output buses when mem_valid is low or mem_excep_en is set.
REQ-031 SHALL achieve single-cycle occupancy for non-memory instructions and for stores whose data_ok arrives in the cycle after entry.

Reset
REQ-032 SHALL, while resetn low, clear mem_valid, discard_cnt, result buffer-valid flag and all stage fields to zero asynchronously.
REQ-033 SHALL, after reset, drive mem_allowin=1, mem_to_wb_valid=0, both buses' valid/we bits 0.
REQ-034 SHALL treat a reset mid-wait as abandoning the request; no data_ok is expected after reset.

Verification
REQ-035 SHALL test ld.b, addr 0x1003, rdata 0x80xxxxxx -> result 0xFFFFFF80; ld.bu -> 0x00000080.
REQ-036 SHALL test ld.h, addr 0x1002, rdata 0x8001xxxx, data_ok 3 cycles late -> mem_allowin low 3 cycles, stall_load high, result 0xFFFF8001.
REQ-037 SHALL test flush while load is waiting and a second request is entering -> discard_cnt=2; next two data_ok dropped; mem_to_wb_valid stays 0.
REQ-038 SHALL test data_ok while wb_allowin=0 for 2 cycles -> result 0x12345678 buffered, delivered unchanged when wb_allowin rises.
REQ-039 SHALL test back-to-back ALU ops with wb_allowin=1 -> one instruction per cycle, result equals ex_alu_result.
REQ-040 SHALL test resetn pulled low mid-wait -> all outputs at reset values immediately, without waiting for a clk edge.
